// File: rtl/pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_issue_ctrl
//
// ID-stage issue controller for a 5-stage RV32 pipeline. Every cycle it
// decides whether the instruction in ID advances to EX, stalls in ID, or is
// squashed. It handles four cases:
//   - load-use hazards against a load currently in EX
//   - taken branch/jump redirects resolved in EX
//   - data-memory back-pressure, which freezes the whole pipeline
//   - CSR serialization: a CSR issues only into an empty EX..WB pipe, and
//     nothing follows it until it has retired
//
// Ports:
//   clk, rst_n          pipeline clock, asynchronous active-low reset
//   id_valid            IF/ID register holds a real instruction
//   id_rs1/id_rs2       decoded source registers
//   id_use_rs1/rs2      instruction actually reads rs1/rs2
//   id_rd, id_regwrite  destination register and its write enable
//   id_memread          instruction is a load
//   id_csr              instruction is a CSR access
//   ex_redirect         EX resolved a taken branch/jump this cycle
//   mem_busy            data memory not ready; whole pipeline holds
//   issue               ID instruction enters EX this cycle
//   stall_pc            hold PC
//   stall_ifid          hold IF/ID register
//   flush_ifid          clear IF/ID valid
//   bubble_idex         load a NOP into ID/EX
//   freeze              hold ID/EX, EX/MEM, MEM/WB
//   ctrl_state          0 RUN, 1 DRAIN, 2 CSR_WAIT
// ---------------------------------------------------------------------------
module pipe_issue_ctrl #(
    parameter int DRAIN_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       id_csr,
    input  logic       ex_redirect,
    input  logic       mem_busy,
    output logic       issue,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       flush_ifid,
    output logic       bubble_idex,
    output logic       freeze,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        CSR_WAIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [DRAIN_DEPTH-1:0] pipe_vld;
    logic                   ex_ld_vld;
    logic [4:0]             ex_ld_rd;

    logic inflight;
    logic hazard;
    logic use_run;

    logic issue_c;
    logic stall_pc_c;
    logic stall_ifid_c;
    logic flush_ifid_c;
    logic bubble_idex_c;
    logic freeze_c;

    assign inflight = |pipe_vld;

    // Only a load sitting in EX can create a hazard: anything older has
    // already produced its result and reaches ID through forwarding.
    assign hazard = id_valid & ex_ld_vld & (ex_ld_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_ld_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_ld_rd)));

    // -----------------------------------------------------------------------
    // State and tracking registers. Everything holds while the pipe is
    // frozen so the occupancy picture stays aligned with the real pipeline.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pipe_vld  <= '0;
            ex_ld_vld <= 1'b0;
            ex_ld_rd  <= 5'd0;
        end else if (!freeze_c) begin
            state     <= next_state;
            pipe_vld  <= {pipe_vld[DRAIN_DEPTH-2:0], issue_c};
            ex_ld_vld <= issue_c & id_memread & id_regwrite;
            ex_ld_rd  <= id_rd;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode. mem_busy outranks the redirect because
    // EX holds and re-presents the redirect once memory is ready again.
    // -----------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        use_run       = 1'b0;
        issue_c       = 1'b0;
        stall_pc_c    = 1'b0;
        stall_ifid_c  = 1'b0;
        flush_ifid_c  = 1'b0;
        bubble_idex_c = 1'b0;
        freeze_c      = 1'b0;

        if (mem_busy) begin
            freeze_c     = 1'b1;
            stall_pc_c   = 1'b1;
            stall_ifid_c = 1'b1;
        end else if (ex_redirect) begin
            // ID holds a wrong-path instruction, including any pending CSR.
            flush_ifid_c  = 1'b1;
            bubble_idex_c = 1'b1;
            next_state    = RUN;
        end else begin
            case (state)
                RUN: begin
                    use_run = 1'b1;
                end
                DRAIN: begin
                    if (inflight) begin
                        stall_pc_c    = 1'b1;
                        stall_ifid_c  = 1'b1;
                        bubble_idex_c = 1'b1;
                    end else begin
                        issue_c    = 1'b1;
                        next_state = CSR_WAIT;
                    end
                end
                CSR_WAIT: begin
                    if (inflight) begin
                        stall_pc_c    = 1'b1;
                        stall_ifid_c  = 1'b1;
                        bubble_idex_c = 1'b1;
                    end else begin
                        // CSR retired: the ID instruction is handled as in
                        // RUN without losing a cycle.
                        use_run    = 1'b1;
                        next_state = RUN;
                    end
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end

        if (use_run) begin
            if (hazard) begin
                stall_pc_c    = 1'b1;
                stall_ifid_c  = 1'b1;
                bubble_idex_c = 1'b1;
            end else if (id_valid & id_csr & inflight) begin
                stall_pc_c    = 1'b1;
                stall_ifid_c  = 1'b1;
                bubble_idex_c = 1'b1;
                next_state    = DRAIN;
            end else if (id_valid & id_csr) begin
                issue_c    = 1'b1;
                next_state = CSR_WAIT;
            end else begin
                issue_c       = id_valid;
                bubble_idex_c = ~id_valid;
            end
        end
    end

    // Outputs are forced low for as long as reset is asserted.
    assign issue       = rst_n & issue_c;
    assign stall_pc    = rst_n & stall_pc_c;
    assign stall_ifid  = rst_n & stall_ifid_c;
    assign flush_ifid  = rst_n & flush_ifid_c;
    assign bubble_idex = rst_n & bubble_idex_c;
    assign freeze      = rst_n & freeze_c;
    assign ctrl_state  = rst_n ? state : RUN;

endmodule
